mtr_drv_pwm: RTL and testbench
==============================

Name: mtr_drv_pwm

Overview:
- Consumer end of the speed/direction interface driven by the balance controller: lft_spd/lft_rev and rght_spd/rght_rev in, H-bridge gate drives out.
- Per motor: 11-bit PWM from a shared free-running counter, duty latched at period boundaries, complementary hi/lo gates with dead time.
- Direction reversals are sequenced through a one-period all-off gap so a bridge never switches direction mid-conduction.

Parameters:
DEAD_TIME, 6'd32, clocks between one gate of a pair deasserting and the other asserting; legal range 1..63.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pwr_up  input  1  enables gate drive; low forces gates off
lft_spd  input  11  unsigned left duty, 0..2047
lft_rev  input  1  left direction request (1 = reverse)
rght_spd  input  11  unsigned right duty
rght_rev  input  1  right direction request
lft_hi  output  1  left high-side gate
lft_lo  output  1  left low-side gate
lft_dir  output  1  left bridge direction currently applied
rght_hi  output  1  right high-side gate
rght_lo  output  1  right low-side gate
rght_dir  output  1  right bridge direction currently applied
pwm_synch  output  1  one-clock pulse on the first cycle of each PWM period

Behaviour:
- Reset: cnt=0, latched duties=0, both side FSMs in RUN, all hi/lo/dir=0, pwm_synch=0.
- Counter:
  - cnt is 11 bits, increments every clock, wraps 2047->0; period = 2048 clocks.
  - The counter runs regardless of pwr_up.
  - pwm_synch is registered and is high in the clock where cnt==0.
- Duty latch:
  - In the cycle cnt==2047, each side samples its spd and rev inputs.
  - Changes to spd mid-period have no effect until that boundary.
- raw PWM per side: raw = (cnt < duty_lat). duty 0 gives raw always 0; duty 2047 gives raw low for exactly 1 clock per period.
- Dead time (per side, all outputs registered):
  - dt counter clears on any raw change and increments, saturating at DEAD_TIME.
  - hi = raw & (dt==DEAD_TIME) & gate_en.
  - lo = ~raw & (dt==DEAD_TIME) & gate_en.
  - A pulse shorter than DEAD_TIME never asserts its gate.
  - hi and lo are never simultaneously 1, including at reset release and on pwr_up edges.
- Side FSM states: RUN, GAP, OFF.
  - RUN: gate_en=1.
    - At boundary, sampled rev != dir: go to GAP. Gates drop 1 clock later; no new dt wait is required.
    - pwr_up low: go to OFF.
  - GAP: gate_en=0 for one full period.
    - At the next boundary, dir <= sampled rev, duty_lat <= sampled spd, go to RUN.
    - If rev toggled back during GAP, dir is unchanged and the FSM still returns to RUN.
  - OFF: gate_en=0.
    - Entered from any state 1 clock after pwr_up is sampled low, mid-period included.
    - Exits to RUN only at a boundary where pwr_up is high. dir <= sampled rev on exit, with no GAP.
  - Precedence: pwr_up low beats reversal; OFF is entered even from GAP.
- Sides are independent; both may reverse in the same boundary.
- Reset mid-operation: all outputs drop to 0 asynchronously.

Optional Feature:
- Macro: MTR_BRAKE_EN.
- Defined: in OFF and GAP both lo outputs are held 1 (low-side brake) and hi is held 0.
  - On leaving the state, lo stays asserted until raw rises.
  - hi then follows the normal dead-time rule.
- Undefined: in OFF and GAP all gates are 0 (coast).

Test Plan:
- Reset, then pwr_up=1, lft_spd=1024, lft_rev=0, DEAD_TIME=32:
  - From the first full period: lft_hi high 992 clocks/period, lft_lo high 992 clocks/period.
  - Two 32-clock all-off gaps per period; lft_dir=0.
  - pwm_synch every 2048 clocks.
- lft_spd=0 -> lft_hi never asserts, lft_lo continuously 1 after the first 32 clocks. lft_spd=2047 -> lft_lo never asserts, lft_hi low 33 clocks/period.
- rght_spd=20 (< DEAD_TIME) -> rght_hi never asserts; rght_lo high 2028-32=1996 clocks/period.
- lft_rev 0->1 mid-period with spd=600 -> current period completes, next full period lft_hi=lft_lo=0, lft_dir=1 at the following boundary, then 568 hi clocks/period.
- pwr_up dropped at cnt=500 -> all gates 0 by next clock. pwr_up restored at cnt=100 -> gates stay 0 until the next cnt==0, then resume with no GAP.
- Assertion across all tests: never (hi & lo) on either side. Change spd at cnt=1000 -> gate timing changes only after the next pwm_synch.

Source files
------------

// File: rtl/mtr_drv_pwm.sv
// Dual H-bridge PWM gate driver: shared 11-bit period counter, per-side duty latch,
// dead-time gating and reversal sequencing. Optional low-side braking: `define MTR_BRAKE_EN.
module mtr_drv_pwm #(
  parameter logic [5:0] DEAD_TIME = 6'd32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  output logic        lft_hi,
  output logic        lft_lo,
  output logic        lft_dir,
  output logic        rght_hi,
  output logic        rght_lo,
  output logic        rght_dir,
  output logic        pwm_synch
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    GAP = 2'd1,
    OFF = 2'd2
  } side_state_e;

  logic [10:0] cnt_q, cnt_d;
  logic        synch_q;
  logic        boundary;

  logic [10:0] spd_in [2];
  logic [1:0]  rev_in;
  logic [1:0]  hi_w, lo_w, dir_w;

  assign spd_in[0] = lft_spd;
  assign spd_in[1] = rght_spd;
  assign rev_in    = {rght_rev, lft_rev};

  assign cnt_d    = cnt_q + 11'd1;
  assign boundary = (cnt_q == 11'h7FF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 11'd0;
      synch_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      synch_q <= boundary;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_side
    side_state_e state_q, state_d;
    logic [10:0] duty_q, duty_d;
    logic        dir_q, dir_d;
    logic        raw, raw_q;
    logic [5:0]  dt_q, dt_d;
    logic        dt_ok;
    logic        gate_en;
    logic        hi_q, hi_d, lo_q, lo_d;
`ifdef MTR_BRAKE_EN
    logic        hold_q, hold_d;
`endif

    assign raw     = (cnt_q < duty_q);
    assign gate_en = (state_q == RUN) && pwr_up;

    // Duty is re-latched at every boundary; direction only changes on GAP/OFF exit.
    always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      duty_d  = boundary ? spd_in[s] : duty_q;
      case (state_q)
        RUN: begin
          if (!pwr_up) begin
            state_d = OFF;
          end else if (boundary && (rev_in[s] != dir_q)) begin
            state_d = GAP;
          end
        end
        GAP: begin
          if (!pwr_up) begin
            state_d = OFF;
          end else if (boundary) begin
            dir_d   = rev_in[s];
            state_d = RUN;
          end
        end
        OFF: begin
          if (pwr_up && boundary) begin
            dir_d   = rev_in[s];
            state_d = RUN;
          end
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end

    // Dead-time counter keeps running while gated off, so a return to RUN needs no extra wait.
    always_comb begin
      dt_d = dt_q;
      if (raw != raw_q) begin
        dt_d = 6'd0;
      end else if (dt_q < DEAD_TIME) begin
        dt_d = dt_q + 6'd1;
      end
      dt_ok = (dt_d == DEAD_TIME);
      hi_d  = raw & dt_ok & gate_en;
`ifdef MTR_BRAKE_EN
      hold_d = ~gate_en | (hold_q & ~raw);
      lo_d   = ~gate_en | (~raw & (dt_ok | hold_q));
`else
      lo_d   = ~raw & dt_ok & gate_en;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= RUN;
        duty_q  <= 11'd0;
        dir_q   <= 1'b0;
        raw_q   <= 1'b0;
        dt_q    <= 6'd0;
        hi_q    <= 1'b0;
        lo_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        duty_q  <= duty_d;
        dir_q   <= dir_d;
        raw_q   <= raw;
        dt_q    <= dt_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
      end
    end

`ifdef MTR_BRAKE_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
      end
    end
`endif

    assign hi_w[s]  = hi_q;
    assign lo_w[s]  = lo_q;
    assign dir_w[s] = dir_q;
  end

  assign lft_hi    = hi_w[0];
  assign lft_lo    = lo_w[0];
  assign lft_dir   = dir_w[0];
  assign rght_hi   = hi_w[1];
  assign rght_lo   = lo_w[1];
  assign rght_dir  = dir_w[1];
  assign pwm_synch = synch_q;

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: directed and random steps checked every clock against a
// period-level reference model plus per-period on-time counts.
module tb_mtr_drv_pwm;

  localparam int DT     = 32;
  localparam int PERIOD = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwr_up = 1'b0;
  logic [10:0] lft_spd = 11'd0;
  logic        lft_rev = 1'b0;
  logic [10:0] rght_spd = 11'd0;
  logic        rght_rev = 1'b0;
  logic        lft_hi, lft_lo, lft_dir;
  logic        rght_hi, rght_lo, rght_dir;
  logic        pwm_synch;

  int compared = 0;
  int mismatched = 0;

  // Reference model: current counter value, latched duty, period-level mode flags,
  // and a window of the last DT+1 raw PWM samples per side.
  int mCnt;
  int mDuty [2];
  bit mOff [2];
  bit mGap [2];
  bit mDir [2];
  bit histBuf [2][DT+1];
  int histLen [2];

  int hiCnt [2];
  int loCnt [2];
  int synchCnt;
  int randSpd;

  always #5 clk = ~clk;

  mtr_drv_pwm #(.DEAD_TIME(6'd32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_up   (pwr_up),
    .lft_spd  (lft_spd),
    .lft_rev  (lft_rev),
    .rght_spd (rght_spd),
    .rght_rev (rght_rev),
    .lft_hi   (lft_hi),
    .lft_lo   (lft_lo),
    .lft_dir  (lft_dir),
    .rght_hi  (rght_hi),
    .rght_lo  (rght_lo),
    .rght_dir (rght_dir),
    .pwm_synch(pwm_synch)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit pwr, input int ls, input bit lr, input int rs, input bit rr);
    pwr_up   = pwr;
    lft_spd  = 11'(ls);
    lft_rev  = lr;
    rght_spd = 11'(rs);
    rght_rev = rr;
  endtask

  // A gate may conduct only if its drive level has been steady for DT+1 consecutive
  // samples and the side is enabled this cycle; the result shows one clock later.
  task automatic stepCycle();
    logic [1:0] expHi, expLo;
    bit expSynch, bnd, raw, stable, en;
    int spdNow [2];
    bit revNow [2];
    spdNow[0] = int'(lft_spd);
    spdNow[1] = int'(rght_spd);
    revNow[0] = lft_rev;
    revNow[1] = rght_rev;
    bnd = (mCnt == PERIOD - 1);
    for (int s = 0; s < 2; s++) begin
      raw = (mCnt < mDuty[s]);
      for (int k = 0; k < DT; k++) histBuf[s][k] = histBuf[s][k+1];
      histBuf[s][DT] = raw;
      if (histLen[s] < DT + 1) histLen[s]++;
      stable = (histLen[s] == DT + 1);
      for (int k = 0; k < DT; k++) if (histBuf[s][k] != raw) stable = 1'b0;
      en = pwr_up && !mOff[s] && !mGap[s];
      expHi[s] = en && raw && stable;
      expLo[s] = en && !raw && stable;
      if (!pwr_up) begin
        mOff[s] = 1'b1;
        mGap[s] = 1'b0;
      end else if (mOff[s] || mGap[s]) begin
        if (bnd) begin
          mOff[s] = 1'b0;
          mGap[s] = 1'b0;
          mDir[s] = revNow[s];
        end
      end else if (bnd && (revNow[s] != mDir[s])) begin
        mGap[s] = 1'b1;
      end
      if (bnd) mDuty[s] = spdNow[s];
    end
    expSynch = bnd;
    mCnt = (mCnt + 1) % PERIOD;
    @(posedge clk);
    #1;
    checkOutput("lft_hi", lft_hi, expHi[0]);
    checkOutput("lft_lo", lft_lo, expLo[0]);
    checkOutput("lft_dir", lft_dir, mDir[0]);
    checkOutput("rght_hi", rght_hi, expHi[1]);
    checkOutput("rght_lo", rght_lo, expLo[1]);
    checkOutput("rght_dir", rght_dir, mDir[1]);
    checkOutput("pwm_synch", pwm_synch, expSynch);
    checkOutput("lft_overlap", lft_hi & lft_lo, 0);
    checkOutput("rght_overlap", rght_hi & rght_lo, 0);
    if (lft_hi === 1'b1) hiCnt[0]++;
    if (lft_lo === 1'b1) loCnt[0]++;
    if (rght_hi === 1'b1) hiCnt[1]++;
    if (rght_lo === 1'b1) loCnt[1]++;
    if (pwm_synch === 1'b1) synchCnt++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic runTo(input int c);
    stepCycle();
    while (mCnt != c) stepCycle();
  endtask

  task automatic measure();
    for (int s = 0; s < 2; s++) begin
      hiCnt[s] = 0;
      loCnt[s] = 0;
    end
    synchCnt = 0;
    runCycles(PERIOD);
  endtask

  initial begin
    mCnt = 0;
    for (int s = 0; s < 2; s++) begin
      mDuty[s] = 0;
      mOff[s] = 1'b0;
      mGap[s] = 1'b0;
      mDir[s] = 1'b0;
      histBuf[s][DT] = 1'b0;
      histLen[s] = 1;
    end

    applyStimulus(1'b1, 1024, 1'b0, 20, 1'b0);
    #12;
    checkOutput("rst_lft_hi", lft_hi, 0);
    checkOutput("rst_lft_lo", lft_lo, 0);
    checkOutput("rst_lft_dir", lft_dir, 0);
    checkOutput("rst_rght_hi", rght_hi, 0);
    checkOutput("rst_rght_lo", rght_lo, 0);
    checkOutput("rst_rght_dir", rght_dir, 0);
    checkOutput("rst_synch", pwm_synch, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Half duty on the left, a sub-dead-time pulse on the right.
    runTo(0);
    measure();
    checkOutput("half_lft_hi_cnt", hiCnt[0], 992);
    checkOutput("half_lft_lo_cnt", loCnt[0], 992);
    checkOutput("short_rght_hi_cnt", hiCnt[1], 0);
    checkOutput("short_rght_lo_cnt", loCnt[1], 1996);
    checkOutput("synch_cnt", synchCnt, 1);

    lft_spd = 11'd0;
    runTo(0);
    measure();
    checkOutput("zero_lft_hi_cnt", hiCnt[0], 0);
    checkOutput("zero_lft_lo_cnt", loCnt[0], PERIOD);

    lft_spd = 11'd2047;
    runTo(0);
    measure();
    checkOutput("full_lft_hi_low", PERIOD - hiCnt[0], 33);
    checkOutput("full_lft_lo_cnt", loCnt[0], 0);

    // Reversal requested mid-period: one dark period, then the new direction.
    lft_spd = 11'd600;
    runTo(0);
    runTo(700);
    lft_rev = 1'b1;
    runTo(0);
    measure();
    checkOutput("gap_lft_hi_cnt", hiCnt[0], 0);
    checkOutput("gap_lft_lo_cnt", loCnt[0], 0);
    measure();
    checkOutput("rev_lft_hi_cnt", hiCnt[0], 568);
    checkOutput("rev_lft_lo_cnt", loCnt[0], 1416);
    checkOutput("rev_lft_dir", lft_dir, 1);

    runTo(500);
    pwr_up = 1'b0;
    stepCycle();
    checkOutput("pwroff_gates", {lft_hi, lft_lo, rght_hi, rght_lo}, 0);
    runTo(100);
    pwr_up = 1'b1;
    runTo(0);
    measure();
    checkOutput("resume_lft_hi_cnt", hiCnt[0], 568);
    checkOutput("resume_rght_lo_cnt", loCnt[1], 1996);

    runTo(1000);
    randSpd = int'($urandom_range(100, 1900));
    lft_spd = 11'(randSpd);
    rght_spd = 11'($urandom_range(0, 2047));
    runTo(0);
    measure();
    checkOutput("midchg_lft_hi_cnt", hiCnt[0], randSpd - DT);

    for (int i = 0; i < 12; i++) begin
      runCycles(int'($urandom_range(1, 1500)));
      applyStimulus($urandom_range(0, 5) != 0, int'($urandom_range(0, 2047)),
                    ($urandom_range(0, 3) == 0) ? ~lft_rev : lft_rev,
                    int'($urandom_range(0, 2047)),
                    ($urandom_range(0, 3) == 0) ? ~rght_rev : rght_rev);
    end
    applyStimulus(1'b1, 1500, lft_rev, 1200, rght_rev);
    runCycles(2 * PERIOD + 300);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_gates", {lft_hi, lft_lo, rght_hi, rght_lo}, 0);
    checkOutput("async_rst_dir", {lft_dir, rght_dir, pwm_synch}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
